// File: rtl/fifo_2d_64to22_pkg.sv
// Shared format definitions for the 64-bit word <-> 22-bit chunk converters.
// The 22-to-64 packer imports the same constants so both sides agree on
// chunk order (MSB-first) and on the 2-bit zero pad that fills chunk2.
//
// Contents:
//   WORD_W / CHUNK_W        : word and chunk widths
//   CHUNK_CNT_FULL / _SHORT : chunks per full / short word
//   CHUNK0_LSB / CHUNK1_LSB : bit offsets of chunk0 and chunk1 in a word
//   CHUNK2_PAD_W            : zero bits appended below word[19:0] for chunk2
//   slot_t                  : one buffered word plus its short flag
//   last_idx()              : index of the final chunk of a word
package fifo_2d_64to22_pkg;

  localparam int WORD_W          = 64;
  localparam int CHUNK_W         = 22;
  localparam int CHUNK_CNT_FULL  = 3;
  localparam int CHUNK_CNT_SHORT = 2;
  localparam int CHUNK0_LSB      = 42;
  localparam int CHUNK1_LSB      = 20;
  localparam int CHUNK2_PAD_W    = 2;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              is_short;
  } slot_t;

  function automatic logic [1:0] last_idx(input logic is_short);
    return is_short ? 2'(CHUNK_CNT_SHORT - 1) : 2'(CHUNK_CNT_FULL - 1);
  endfunction

endpackage

// File: rtl/fifo_2d_64to22_if.sv
// Upstream word bus and downstream chunk bus of the 64-to-22 unpacker.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holds its data stable while valid is high and
// ready is low; valid never waits on ready, and ready may be low at any time.
//
// Signals:
//   a_data[63:0], a_short, a_valid  : word from the producer
//   a_ready                         : unpacker can take a word
//   b_data[21:0], b_last, b_valid   : chunk to the consumer
//   b_ready                         : consumer takes the chunk
// Modports:
//   slave  : the unpacker side
//   master : the producer/consumer side (e.g. a testbench)
interface fifo_2d_64to22_if;
  import fifo_2d_64to22_pkg::*;

  logic [WORD_W-1:0]  a_data;
  logic               a_short;
  logic               a_valid;
  logic               a_ready;
  logic [CHUNK_W-1:0] b_data;
  logic               b_last;
  logic               b_valid;
  logic               b_ready;

  modport slave (
    input  a_data, a_short, a_valid, b_ready,
    output a_ready, b_data, b_last, b_valid
  );

  modport master (
    output a_data, a_short, a_valid, b_ready,
    input  a_ready, b_data, b_last, b_valid
  );

endinterface

// File: rtl/fifo_2d_64to22_chunk_sel.sv
// Combinational chunk selector: picks chunk[idx] out of a 64-bit word and
// flags whether it is the final chunk of that word.
//
// Ports:
//   word[63:0] : buffered word
//   idx[1:0]   : chunk index (0..2)
//   is_short   : word carries 2 chunks instead of 3
//   chunk[21:0]: selected chunk
//   last       : idx is the final chunk index for this word
module fifo_2d_64to22_chunk_sel
  import fifo_2d_64to22_pkg::*;
(
  input  logic [WORD_W-1:0]  word,
  input  logic [1:0]         idx,
  input  logic               is_short,
  output logic [CHUNK_W-1:0] chunk,
  output logic               last
);

  always_comb begin
    chunk = '0;
    case (idx)
      2'd0:    chunk = word[CHUNK0_LSB +: CHUNK_W];
      2'd1:    chunk = word[CHUNK1_LSB +: CHUNK_W];
      // chunk2 only has 20 payload bits; pad the low end with zeros
      default: chunk = {word[CHUNK1_LSB-1:0], {CHUNK2_PAD_W{1'b0}}};
    endcase
  end

  assign last = (idx == last_idx(is_short));

endmodule

// File: rtl/fifo_2d_64to22.sv
// Width converter: unpacks 64-bit words into 22-bit chunks, MSB-first.
// A full word yields 3 chunks, a short word 2. A 2-slot word buffer lets the
// producer deposit the next word while the current one is being emitted, so
// chunks stream at one per cycle with no bubble between words.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   flush : synchronous discard of buffered words and chunk progress;
//           wins over any push or pop in the same cycle
//   bus   : fifo_2d_64to22_if.slave (a_* word input, b_* chunk output)
module fifo_2d_64to22
  import fifo_2d_64to22_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  fifo_2d_64to22_if.slave        bus
);

  slot_t      slot_q [2];
  slot_t      slot_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic [1:0] idx_q, idx_d;

  slot_t              head;
  logic [CHUNK_W-1:0] sel_chunk;
  logic               sel_last;
  logic               b_valid_w;
  logic               a_ready_w;
  logic               push;
  logic               pop;
  logic               word_done;

  assign head      = slot_q[rd_ptr_q];
  assign b_valid_w = (count_q != 2'd0);
  // Depends on registered count only: a word completing this cycle does not
  // open the buffer until the next cycle.
  assign a_ready_w = (count_q != 2'd2) & ~rst;

  fifo_2d_64to22_chunk_sel u_chunk_sel (
    .word     (head.data),
    .idx      (idx_q),
    .is_short (head.is_short),
    .chunk    (sel_chunk),
    .last     (sel_last)
  );

  assign bus.a_ready = a_ready_w;
  assign bus.b_valid = b_valid_w;
  assign bus.b_data  = b_valid_w ? sel_chunk : '0;
  assign bus.b_last  = b_valid_w & sel_last;

  assign push      = bus.a_valid & a_ready_w;
  assign pop       = b_valid_w & bus.b_ready;
  assign word_done = pop & sel_last;

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idx_d    = idx_q;
    if (flush) begin
      // Slot contents are left as-is; count = 0 makes them unreachable.
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
      idx_d    = 2'd0;
    end else begin
      if (push) begin
        slot_d[wr_ptr_q] = '{data: bus.a_data, is_short: bus.a_short};
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        if (sel_last) begin
          rd_ptr_d = ~rd_ptr_q;
          idx_d    = 2'd0;
        end else begin
          idx_d    = idx_q + 2'd1;
        end
      end
      case ({push, word_done})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      idx_q     <= 2'd0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
    end
  end

endmodule
